// File: rtl/ipml_sync_pack_fifo.sv
// ipml_sync_pack_fifo: single-clock FIFO that packs c_RATIO narrow write words
// into one wide read word (lane 0 = first word written). Supports standard and
// first-word-fall-through reads, partial-word pad/commit, water levels,
// almost thresholds and sticky overflow/underflow flags.
module ipml_sync_pack_fifo #(
  parameter int c_WR_DATA_WIDTH    = 16,
  parameter int c_RATIO            = 4,
  parameter int c_RD_DEPTH_WIDTH   = 9,
  parameter int c_FWFT             = 0,
  parameter int c_ALMOST_FULL_NUM  = 2040,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [c_WR_DATA_WIDTH-1:0]                 wr_data,
  input  logic                                       wr_en,
  input  logic                                       wr_pad,
  output logic                                       wr_full,
  output logic                                       almost_full,
  output logic [c_RD_DEPTH_WIDTH+$clog2(c_RATIO):0]  wr_water_level,
  output logic [c_WR_DATA_WIDTH*c_RATIO-1:0]         rd_data,
  input  logic                                       rd_en,
  output logic                                       rd_empty,
  output logic                                       almost_empty,
  output logic [c_RD_DEPTH_WIDTH:0]                  rd_water_level,
  output logic                                       overflow,
  output logic                                       underflow
);

  localparam int W   = c_WR_DATA_WIDTH;
  localparam int RW  = c_WR_DATA_WIDTH * c_RATIO;
  localparam int LR  = $clog2(c_RATIO);
  localparam int WLW = c_RD_DEPTH_WIDTH + LR + 1;
  localparam int DW  = c_RD_DEPTH_WIDTH;
  localparam int D   = 1 << c_RD_DEPTH_WIDTH;
  // c_RATIO=1 has no pack lanes; keep one dummy lane so the array is legal.
  localparam int PL  = (c_RATIO > 1) ? c_RATIO - 1 : 1;
  localparam int PCW = (LR > 0) ? LR : 1;
  localparam logic [31:0] AF_NUM = 32'(c_ALMOST_FULL_NUM);
  localparam logic [31:0] AE_NUM = 32'(c_ALMOST_EMPTY_NUM);

  logic [W-1:0]   pack_q [PL];
  logic [W-1:0]   pack_d [PL];
  logic [PCW-1:0] pack_cnt_q, pack_cnt_d;
  logic [DW-1:0]  wptr_q, wptr_d;
  logic [DW-1:0]  rptr_q, rptr_d;
  logic [DW:0]    cnt_q, cnt_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic [RW-1:0]  mem [D];

  logic           wr_acc;
  logic           rd_acc;
  logic           last_lane;
  logic           commit;
  logic [RW-1:0]  commit_word;

  // Status decoded purely from registered state.
  assign wr_water_level = (WLW'(cnt_q) << LR) + WLW'(pack_cnt_q);
  assign rd_water_level = cnt_q;
  assign wr_full        = (wr_water_level == WLW'(D * c_RATIO));
  assign rd_empty       = (cnt_q == '0);
  assign almost_full    = (32'(wr_water_level) >= AF_NUM);
  assign almost_empty   = (32'(cnt_q) <= AE_NUM);
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  assign wr_acc    = wr_en & ~wr_full;
  assign rd_acc    = rd_en & ~rd_empty;
  assign last_lane = (pack_cnt_q == PCW'(c_RATIO - 1));
  // A pad commits whatever is pending after this cycle's write, if anything.
  assign commit    = (wr_acc & last_lane) | (wr_pad & ((pack_cnt_q != '0) | wr_acc));

  // Assemble the committed word: filled lanes, this cycle's write, zeros above.
  always_comb begin
    commit_word = '0;
    for (int i = 0; i < PL; i++) begin
      if (PCW'(i) < pack_cnt_q) commit_word[i*W +: W] = pack_q[i];
    end
    if (wr_acc) begin
      for (int i = 0; i < c_RATIO; i++) begin
        if (PCW'(i) == pack_cnt_q) commit_word[i*W +: W] = wr_data;
      end
    end
  end

  // Next-state for pack register, pointers, count and sticky error flags.
  always_comb begin
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q | (wr_en & wr_full);
    underflow_d = underflow_q | (rd_en & rd_empty);

    if (commit) begin
      pack_cnt_d = '0;
      wptr_d     = wptr_q + DW'(1);
    end else if (wr_acc) begin
      for (int i = 0; i < PL; i++) begin
        if (PCW'(i) == pack_cnt_q) pack_d[i] = wr_data;
      end
      pack_cnt_d = pack_cnt_q + PCW'(1);
    end

    if (rd_acc) rptr_d = rptr_q + DW'(1);

    unique case ({commit, rd_acc})
      2'b10:   cnt_d = cnt_q + (DW+1)'(1);
      2'b01:   cnt_d = cnt_q - (DW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PL; i++) pack_q[i] <= '0;
      pack_cnt_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (commit && !rst) mem[wptr_q] <= commit_word;
  end

  generate
    if (c_FWFT != 0) begin : g_fwft
      // Head word is presented directly; rd_en only advances the pointer.
      assign rd_data = mem[rptr_q];
    end else begin : g_std
      logic [RW-1:0] rd_data_q, rd_data_d;

      // Standard read: capture the head word on an accepted read, else hold.
      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) rd_data_d = mem[rptr_q];
      end

      // Read data register, cleared by reset.
      always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_ipml_sync_pack_fifo.sv
// Testbench for ipml_sync_pack_fifo: randomized and directed stimulus against a
// queue-based reference model; read data checked by a separate monitor.
module tb_ipml_sync_pack_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters (16-bit x4, 512 read words, standard read).
  logic        rst, wr_en, wr_pad, rd_en;
  logic [15:0] wr_data;
  logic        wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
  logic [11:0] wr_water_level;
  logic [9:0]  rd_water_level;
  logic [63:0] rd_data;

  ipml_sync_pack_fifo u_dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_pad(wr_pad),
    .wr_full(wr_full), .almost_full(almost_full), .wr_water_level(wr_water_level),
    .rd_data(rd_data), .rd_en(rd_en), .rd_empty(rd_empty), .almost_empty(almost_empty),
    .rd_water_level(rd_water_level), .overflow(overflow), .underflow(underflow)
  );

  // Second instance: FWFT, ratio 2, 8 read words.
  logic        f_rst, f_wr_en, f_wr_pad, f_rd_en;
  logic [15:0] f_wr_data;
  logic        f_wr_full, f_almost_full, f_rd_empty, f_almost_empty, f_overflow, f_underflow;
  logic [4:0]  f_wr_water_level;
  logic [3:0]  f_rd_water_level;
  logic [31:0] f_rd_data;

  ipml_sync_pack_fifo #(
    .c_WR_DATA_WIDTH(16), .c_RATIO(2), .c_RD_DEPTH_WIDTH(3), .c_FWFT(1),
    .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(1)
  ) u_fw (
    .clk(clk), .rst(f_rst), .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_pad(f_wr_pad),
    .wr_full(f_wr_full), .almost_full(f_almost_full), .wr_water_level(f_wr_water_level),
    .rd_data(f_rd_data), .rd_en(f_rd_en), .rd_empty(f_rd_empty), .almost_empty(f_almost_empty),
    .rd_water_level(f_rd_water_level), .overflow(f_overflow), .underflow(f_underflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending narrow words and stored wide words as queues.
  logic [15:0] pend[$];
  logic [63:0] rq[$];
  logic [63:0] exp_q[$];
  bit          m_ovf, m_unf;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic check_state();
    int wl;
    wl = rq.size() * 4 + pend.size();
    chk("wr_water_level", 64'(wr_water_level), 64'(wl));
    chk("rd_water_level", 64'(rd_water_level), 64'(rq.size()));
    chk("rd_empty",       64'(rd_empty),       64'(rq.size() == 0));
    chk("wr_full",        64'(wr_full),        64'(wl == 2048));
    chk("almost_full",    64'(almost_full),    64'(wl >= 2040));
    chk("almost_empty",   64'(almost_empty),   64'(rq.size() <= 4));
    chk("overflow",       64'(overflow),       64'(m_ovf));
    chk("underflow",      64'(underflow),      64'(m_unf));
  endtask

  // One clock cycle: check current state, drive inputs, advance the model.
  task automatic cycle(input bit we, input logic [15:0] wd, input bit pad, input bit re);
    int          wl;
    bit          full, empty;
    logic [63:0] w;
    check_state();
    wr_en = we; wr_data = wd; wr_pad = pad; rd_en = re;
    wl    = rq.size() * 4 + pend.size();
    full  = (wl == 2048);
    empty = (rq.size() == 0);
    if (re) begin
      if (empty) m_unf = 1'b1;
      else exp_q.push_back(rq.pop_front());
    end
    if (we) begin
      if (full) m_ovf = 1'b1;
      else pend.push_back(wd);
    end
    if (pend.size() == 4 || (pad && pend.size() > 0)) begin
      w = '0;
      foreach (pend[i]) w[i*16 +: 16] = pend[i];
      rq.push_back(w);
      pend.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(0, 16'h0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    rq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("rd_data_after_reset", rd_data, 64'h0);
  endtask

  // Monitor: an accepted read presents its word after the edge.
  initial begin
    bit hs;
    forever begin
      @(posedge clk);
      hs = rd_en && !rd_empty && !rst;
      if (hs) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_data: got %h with no expected word queued", rd_data);
        end else begin
          chk("rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic fw_step(input bit we, input logic [15:0] wd, input bit re);
    f_wr_en = we; f_wr_data = wd; f_rd_en = re;
    @(negedge clk);
  endtask

  logic [15:0] d;

  initial begin
    rst = 1'b1; wr_en = 0; wr_pad = 0; rd_en = 0; wr_data = '0;
    f_rst = 1'b1; f_wr_en = 0; f_wr_pad = 0; f_rd_en = 0; f_wr_data = '0;
    m_ovf = 0; m_unf = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f_rst = 1'b0;
    chk("rd_data_reset", rd_data, 64'h0);

    // FWFT instance: word visible without rd_en, pop, then mid-stream reset.
    chk("fw_rd_empty_reset", 64'(f_rd_empty), 64'd1);
    fw_step(1, 16'h1111, 0);
    chk("fw_rd_empty_half", 64'(f_rd_empty), 64'd1);
    chk("fw_wr_level_half", 64'(f_wr_water_level), 64'd1);
    fw_step(1, 16'h2222, 0);
    fw_step(0, 16'h0, 0);
    chk("fw_rd_empty", 64'(f_rd_empty), 64'd0);
    chk("fw_rd_data", 64'(f_rd_data), 64'h2222_1111);
    fw_step(0, 16'h0, 0);
    chk("fw_rd_data_hold", 64'(f_rd_data), 64'h2222_1111);
    fw_step(1, 16'h3333, 0);
    fw_step(1, 16'h4444, 1);
    chk("fw_rd_data_pop", 64'(f_rd_data), 64'h4444_3333);
    chk("fw_rd_level", 64'(f_rd_water_level), 64'd1);
    chk("fw_wr_level", 64'(f_wr_water_level), 64'd2);
    fw_step(1, 16'h5555, 0);
    chk("fw_wr_level_partial", 64'(f_wr_water_level), 64'd3);
    f_rst = 1'b1;
    fw_step(1, 16'h6666, 0);
    f_rst = 1'b0;
    chk("fw_rd_empty_rst", 64'(f_rd_empty), 64'd1);
    chk("fw_wr_level_rst", 64'(f_wr_water_level), 64'd0);
    chk("fw_rd_level_rst", 64'(f_rd_water_level), 64'd0);
    fw_step(0, 16'h0, 0);

    // Four words then one read.
    for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 0, 0);
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 0);

    // Three words then pad.
    cycle(1, 16'hAAAA, 0, 0);
    cycle(1, 16'hBBBB, 0, 0);
    cycle(1, 16'hCCCC, 0, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 1, 0);   // pad with nothing pending
    cycle(1, 16'hDDDD, 1, 0); // pad together with a single new word
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 0);

    // Fill to full, overflow, write+read at full, then drain past empty.
    for (int i = 0; i < 2048; i++) cycle(1, 16'($urandom), 0, 0);
    cycle(1, 16'h1234, 0, 0);
    cycle(1, 16'h5678, 0, 1);
    cycle(0, 16'h0, 0, 0);
    chk("level_after_full_read", 64'(wr_water_level), 64'd2044);
    for (int i = 0; i < 515; i++) cycle(0, 16'h0, 0, 1);
    do_reset();

    // Underflow after reset, rd_data stays 0, reset clears the flag.
    cycle(0, 16'h0, 0, 1);
    chk("rd_data_underflow", rd_data, 64'h0);
    do_reset();

    // Random traffic: write-heavy then read-heavy.
    for (int i = 0; i < 2500; i++)
      cycle(($urandom % 10) != 0, 16'($urandom), ($urandom % 16) == 0, ($urandom % 5) == 0);
    for (int i = 0; i < 2500; i++)
      cycle(($urandom % 3) == 0, 16'($urandom), ($urandom % 8) == 0, ($urandom % 2) == 0);
    do_reset();

    // Steady streaming across three pointer wraps with incrementing data.
    d = 16'h0;
    for (int i = 0; i < 8; i++) begin cycle(1, d, 0, 0); d++; end
    for (int i = 0; i < 6144; i++) begin
      cycle(1, d, 0, (i % 4) == 3);
      d++;
    end
    for (int i = 0; i < 6; i++) cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 0, 0);

    chk("expected_words_left", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ipml_sync_pack_fifo.md
Name: ipml_sync_pack_fifo

Overview:
- Single-clock FIFO that packs c_RATIO narrow write words into one wide read word, least-significant lane first.
- Supports standard and first-word-fall-through read modes, a partial-word pad/commit command, programmable almost-full/almost-empty thresholds, water levels on both sides, and sticky overflow/underflow flags.
- Sits between narrow pixel/capture streams and wide memory-side consumers where both sides share one clock.

Parameters:
- c_WR_DATA_WIDTH, 16, width of one write word; legal 1~256.
- c_RATIO, 4, write words per read word; legal 1, 2, 4, 8.
- c_RD_DEPTH_WIDTH, 9, log2 of storage depth in read words (D = 2^c_RD_DEPTH_WIDTH); legal 2~12.
- c_FWFT, 0, 0 = standard read, 1 = first-word-fall-through.
- c_ALMOST_FULL_NUM, 2040, almost_full threshold in write words.
- c_ALMOST_EMPTY_NUM, 4, almost_empty threshold in read words.
- Derived:
  - RW = c_WR_DATA_WIDTH*c_RATIO.
  - LR = log2(c_RATIO).
  - WLW = c_RD_DEPTH_WIDTH+LR+1.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- wr_data  in  c_WR_DATA_WIDTH  write word
- wr_en  in  1  write request
- wr_pad  in  1  commit partial word with zero-filled upper lanes
- wr_full  out  1  write side full
- almost_full  out  1  wr_water_level >= c_ALMOST_FULL_NUM
- wr_water_level  out  WLW  occupancy in write words
- rd_data  out  RW  read word
- rd_en  in  1  read request
- rd_empty  out  1  no read word stored
- almost_empty  out  1  rd_water_level <= c_ALMOST_EMPTY_NUM
- rd_water_level  out  c_RD_DEPTH_WIDTH+1  stored read words
- overflow  out  1  sticky: wr_en while wr_full
- underflow  out  1  sticky: rd_en while rd_empty

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears pointers, count, pack register, pack_cnt, overflow and underflow.
  - Standard-mode rd_data goes to 0.
  - After reset: rd_empty=1, almost_empty=1, wr_full=0, almost_full=0 (for threshold >0), both levels 0.
  - Reset mid-operation discards all stored and partial data. Memory contents need not clear.
- State:
  - Pack register of c_RATIO-1 lanes plus pack_cnt in 0..c_RATIO-1.
  - RAM of D x RW.
  - Read-word count cnt in 0..D.
- Derived values:
  - wr_water_level = cnt*c_RATIO + pack_cnt.
  - wr_full = (wr_water_level == D*c_RATIO). When full, pack_cnt=0 always.
  - rd_water_level = cnt.
  - rd_empty = (cnt==0).
  - All flags are decoded from registered state only; no combinational path from wr_en/rd_en.
- Write (wr_en && !wr_full):
  - If pack_cnt < c_RATIO-1: wr_data goes to lane pack_cnt; pack_cnt increments.
  - Otherwise: {wr_data, lanes c_RATIO-2..0} is written to RAM at wptr; wptr increments mod D; pack_cnt goes to 0.
  - c_RATIO=1: every accepted write commits directly.
- Pad (wr_pad && pack_cnt>0, after applying any same-cycle write):
  - If the same-cycle write completed a word, pad is a no-op.
  - Otherwise the partial word, with unfilled upper lanes zero, commits at wptr and pack_cnt goes to 0.
  - wr_pad with pack_cnt==0 and no write is a no-op.
  - Pad never needs space, because pack_cnt>0 implies cnt<D.
- Read (rd_en && !rd_empty):
  - rptr increments mod D.
  - c_FWFT=0: rd_data updates at that edge with RAM[rptr], one-cycle latency, and holds otherwise.
  - c_FWFT=1: rd_data = RAM[rptr] combinationally whenever !rd_empty, undefined when empty; rd_en acts as pop.
- Simultaneous commit and read in one cycle: cnt is unchanged.
  - Read at cnt==0 is rejected even if a commit happens that cycle.
  - Write at wr_full is rejected even if a read happens that cycle.
- New data visibility: after a commit, rd_empty falls at the following edge, giving a 1-cycle commit-to-visible latency.
- Error handling: rejected write sets overflow; rejected read sets underflow. State is otherwise unchanged.
- Pointer wrap: pointers wrap naturally at D. Full and empty are distinguished by cnt, not by pointers.

Test Plan:
- Defaults. Write 0x0001,0x0002,0x0003,0x0004 on consecutive cycles, then one rd_en -> rd_data=0x0004_0003_0002_0001 one cycle after rd_en. Levels step 1,2,3,0→rd 1.
- Write 3 words 0xAAAA,0xBBBB,0xCCCC, then wr_pad -> rd_water_level=1, wr_water_level=4. Readback 0x0000_CCCC_BBBB_AAAA.
- Fill to 2048 write words -> wr_full=1, almost_full=1 from level 2040. Extra wr_en sets overflow; level stays 2048. One read -> wr_full=0, level 2044.
- rd_en while empty after reset -> underflow=1, rd_data stays 0. Pulse rst -> underflow=0.
- Steady simultaneous write/read across 3 full pointer wraps with incrementing data -> data order intact, cnt constant, no flags set.
- c_FWFT=1, c_RATIO=2: write 0x1111,0x2222 -> rd_data=0x2222_1111 with rd_empty=0 two edges later, no rd_en needed. rst asserted mid-stream -> rd_empty=1 and both levels 0 next cycle.
